// File: rtl/sync_fifo_cfg.sv
// rtl/sync_fifo_cfg.sv - parametrised single-clock FIFO with thresholds, count, sticky errors and FWFT option
module sync_fifo_cfg #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_rd_en,
    output logic [DATA_WIDTH-1:0]    o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_clr_err,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CW-1:0]         w_count_next;

    // Accept decisions use this cycle's registered flags: no full/empty bypass.
    assign w_wr_acc     = i_wr_en & ~r_full;
    assign w_rd_acc     = i_rd_en & ~r_empty;
    assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    // Storage array, deliberately left without reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointers, occupancy and status flags; flags follow count_next so they match count every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_ONE;
            end
            r_count        <= w_count_next;
            r_full         <= (w_count_next == C_DEPTH);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= C_AFULL);
            r_almost_empty <= (w_count_next <= C_AEMPTY);
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (i_rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end else if (i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; a pop just advances the read pointer.
            assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
            assign o_rd_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // Registered read: data lands one cycle after the accepted pop, and holds otherwise.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                    end
                end
            end

            assign o_rd_data  = r_rd_data;
            assign o_rd_valid = r_rd_valid;
        end
    endgenerate

`ifndef SYNTHESIS
    // Pointer distance, including the wrap bit, must always equal the occupancy count.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (CW'(r_wr_ptr - r_rd_ptr) == r_count);
        end
    end
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// tb/tb_sync_fifo_cfg.sv - self-checking bench for sync_fifo_cfg in standard and FWFT modes
module tb_sync_fifo_cfg;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          clr_err;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_afull, f_afull, s_aempty, f_aempty;
    logic [3:0]    s_count, f_count;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    int n_total = 0;
    int n_bad   = 0;

    // behavioural model: a plain queue plus the sticky flags and the standard-mode read register
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd;
    logic          m_rv;
    logic          m_ovf;
    logic          m_unf;

    always #5 clk = ~clk;

    sync_fifo_cfg #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL),
                    .AEMPTY_THRESH(AEMPTY), .FWFT(0)) u_std (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(s_rd_data), .o_rd_valid(s_rd_valid),
        .o_full(s_full), .o_empty(s_empty), .o_almost_full(s_afull),
        .o_almost_empty(s_aempty), .o_count(s_count), .i_clr_err(clr_err),
        .o_overflow(s_ovf), .o_underflow(s_unf));

    sync_fifo_cfg #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL),
                    .AEMPTY_THRESH(AEMPTY), .FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid),
        .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_afull),
        .o_almost_empty(f_aempty), .o_count(f_count), .i_clr_err(clr_err),
        .o_overflow(f_ovf), .o_underflow(f_unf));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd  = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // one rising edge as seen by the model: inputs are stable at the edge
    task automatic model_edge();
        int  sz;
        logic is_full, is_empty;
        sz       = mq.size();
        is_full  = (sz == DEPTH);
        is_empty = (sz == 0);
        if (wr_en && is_full)       m_ovf = 1'b1;
        else if (clr_err)           m_ovf = 1'b0;
        if (rd_en && is_empty)      m_unf = 1'b1;
        else if (clr_err)           m_unf = 1'b0;
        if (rd_en && !is_empty) begin
            m_rd = mq.pop_front();
            m_rv = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
        if (wr_en && !is_full) mq.push_back(wr_data);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
    endtask

    // every-cycle comparison of both instances against the model, away from the active edge
    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        chk("s_count", 32'(s_count), 32'(sz));
        chk("f_count", 32'(f_count), 32'(sz));
        chk("s_empty", 32'(s_empty), 32'(sz == 0));
        chk("f_empty", 32'(f_empty), 32'(sz == 0));
        chk("s_full", 32'(s_full), 32'(sz == DEPTH));
        chk("f_full", 32'(f_full), 32'(sz == DEPTH));
        chk("s_afull", 32'(s_afull), 32'(sz >= AFULL));
        chk("f_afull", 32'(f_afull), 32'(sz >= AFULL));
        chk("s_aempty", 32'(s_aempty), 32'(sz <= AEMPTY));
        chk("f_aempty", 32'(f_aempty), 32'(sz <= AEMPTY));
        chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
        chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
        chk("s_unf", 32'(s_unf), 32'(m_unf));
        chk("f_unf", 32'(f_unf), 32'(m_unf));
        chk("s_rd_valid", 32'(s_rd_valid), 32'(m_rv));
        chk("s_rd_data", 32'(s_rd_data), 32'(m_rd));
        chk("f_rd_valid", 32'(f_rd_valid), 32'(sz != 0));
        if (sz != 0) chk("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();

        // reset / idle state
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_aempty", 32'(s_aempty), 32'd1);
        chk("rst_full", 32'(s_full), 32'd0);
        chk("rst_afull", 32'(s_afull), 32'd0);
        chk("rst_rd_valid", 32'(s_rd_valid), 32'd0);
        chk("rst_rd_data", 32'(s_rd_data), 32'h00);

        // fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            step();
            if (i == 4) chk("fill_afull_5", 32'(s_afull), 32'd0);
            if (i == 5) chk("fill_afull_6", 32'(s_afull), 32'd1);
            if (i == 6) chk("fill_full_7", 32'(s_full), 32'd0);
        end
        chk("fill_full", 32'(s_full), 32'd1);
        chk("fill_count", 32'(s_count), 32'd8);
        wr_data = 8'hFF;
        step();
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(f_count), 32'd8);
        wr_en = 1'b0;

        // drain in order
        for (int i = 0; i < 8; i++) begin
            chk("fwft_head", 32'(f_rd_data), 32'h10 + 32'(i));
            rd_en = 1'b1;
            step();
            chk("drain_data", 32'(s_rd_data), 32'h10 + 32'(i));
            chk("drain_valid", 32'(s_rd_valid), 32'd1);
            if (i == 5) chk("drain_aempty_2", 32'(s_aempty), 32'd0);
            if (i == 6) chk("drain_aempty_1", 32'(s_aempty), 32'd1);
            if (i == 6) chk("drain_empty_1", 32'(s_empty), 32'd0);
        end
        chk("drain_empty", 32'(s_empty), 32'd1);
        step();
        chk("unf_set", 32'(s_unf), 32'd1);
        chk("unf_hold_data", 32'(s_rd_data), 32'h17);
        chk("unf_valid", 32'(s_rd_valid), 32'd0);
        rd_en = 1'b0;

        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_ovf", 32'(s_ovf), 32'd0);
        chk("clr_unf", 32'(s_unf), 32'd0);

        // hold count at 4 with concurrent traffic across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i); step();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h24 + 8'(i);
            step();
            chk("wrap_count", 32'(s_count), 32'd4);
            chk("wrap_data", 32'(s_rd_data), 32'h20 + 32'(i));
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h40 + 8'(i); step();
        end
        chk("wrap_full", 32'(s_full), 32'd1);
        wr_data = 8'hEE; rd_en = 1'b1;
        step();
        chk("full_rw_count", 32'(s_count), 32'd7);
        chk("full_rw_ovf", 32'(s_ovf), 32'd1);
        chk("full_rw_data", 32'(s_rd_data), 32'h34);
        rd_en = 1'b0;
        wr_data = 8'h50; step();
        chk("refill_full", 32'(s_full), 32'd1);
        clr_err = 1'b1; wr_data = 8'h66; step();
        chk("clr_vs_ovf", 32'(s_ovf), 32'd1);
        wr_en = 1'b0; step();
        chk("clr_alone", 32'(s_ovf), 32'd0);
        clr_err = 1'b0;

        // empty it, then FWFT behaviour
        rd_en = 1'b1;
        repeat (8) step();
        rd_en = 1'b0;
        chk("pre_fwft_empty", 32'(f_empty), 32'd1);
        wr_en = 1'b1; wr_data = 8'hA5; step(); wr_en = 1'b0;
        chk("fwft_data", 32'(f_rd_data), 32'hA5);
        chk("fwft_valid", 32'(f_rd_valid), 32'd1);
        chk("std_no_valid", 32'(s_rd_valid), 32'd0);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("fwft_pop_valid", 32'(f_rd_valid), 32'd0);
        chk("std_pop_data", 32'(s_rd_data), 32'hA5);
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h5A; step();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_empty_count", 32'(f_count), 32'd1);
        chk("rw_empty_unf", 32'(f_unf), 32'd1);
        chk("rw_empty_data", 32'(f_rd_data), 32'h5A);

        // asynchronous reset with count=5
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h70 + 8'(i); step();
        end
        wr_en = 1'b0;
        chk("pre_rst_count", 32'(s_count), 32'd5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_s_count", 32'(s_count), 32'd0);
        chk("arst_f_count", 32'(f_count), 32'd0);
        chk("arst_s_empty", 32'(s_empty), 32'd1);
        chk("arst_f_valid", 32'(f_rd_valid), 32'd0);
        chk("arst_unf", 32'(f_unf), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
